// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two sequential half-word accesses
// on a 16-bit asynchronous SRAM, low half first, holding `ready` low meanwhile.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] DATA_BASE     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] sramData,
  output logic [17:0] sramAddress,
  output logic [4:0]  sramCtrl,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} stateT;

  // Handshake: a request is taken in IDLE when wrEn|rdEn is high; ready=0 tells
  // the requester to hold address/data/enables until the single DONE cycle.

  stateT       state, stateNext;
  logic [3:0]  count, countNext;
  logic        isWrite;
  logic [16:0] index;
  logic [16:0] reqIndex;
  logic [31:0] dataLatch;
  logic        lastCount;
  logic        request;
  logic        driveBus;

  assign request   = wrEn | rdEn;
  assign reqIndex  = 17'((address - DATA_BASE) >> 2);
  assign lastCount = (count == 4'(ACCESS_CYCLES - 1));

  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      IDLE: begin
        if (request) begin
          stateNext = LOW;
          countNext = 4'd0;
        end
      end
      LOW: begin
        if (lastCount) begin
          stateNext = HIGH;
          countNext = 4'd0;
        end else begin
          countNext = count + 4'd1;
        end
      end
      HIGH: begin
        if (lastCount) begin
          stateNext = DONE;
          countNext = 4'd0;
        end else begin
          countNext = count + 4'd1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 4'd0;
      isWrite     <= 1'b0;
      index       <= 17'd0;
      dataLatch   <= 32'd0;
      readData    <= 32'd0;
      sramAddress <= 18'd0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (state == IDLE && request) begin
        // A write wins when both enables are raised together.
        isWrite     <= wrEn;
        index       <= reqIndex;
        dataLatch   <= writeData;
        sramAddress <= {reqIndex, 1'b0};
      end
      if (state == LOW && lastCount) begin
        sramAddress <= {index, 1'b1};
        if (!isWrite) readData[15:0] <= sramData;
      end
      if (state == HIGH && lastCount && !isWrite) readData[31:16] <= sramData;
    end
  end

  // Bus drive and WE_N derive only from registered state, so WE_N cannot dip
  // low in IDLE or DONE.
  assign driveBus = isWrite && (state == LOW || state == HIGH);
  assign sramData = driveBus ? ((state == HIGH) ? dataLatch[31:16] : dataLatch[15:0])
                             : 16'hzzzz;
  assign sramCtrl = {~driveBus, 4'b0000};
  assign ready    = ((state == IDLE) && !request) || (state == DONE);
  assign dbgState = state;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: three instances (ACCESS_CYCLES 2, 1, 3),
// each attached to its own behavioural SRAM that commits a write only after WE_N
// has been held low at one address for a full phase.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wrEnV [3];
  logic        rdEnV [3];
  logic [31:0] addrV [3];
  logic [31:0] wdataV [3];
  logic [31:0] rdObs [3];
  logic        rdyObs [3];
  logic [17:0] addrObs [3];
  logic [4:0]  ctrlObs [3];
  logic [1:0]  stObs [3];
  logic [15:0] busObs [3];
  logic [15:0] mem [3][64];
  int          weRun [3];
  logic [17:0] lastAddr [3];

  int nChecks = 0;
  int nFails  = 0;

  function automatic int acOf(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : gDut
      localparam int AC = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
      wire [15:0] bus;
      sram_controller #(.ACCESS_CYCLES(AC), .DATA_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEnV[g]), .rdEn(rdEnV[g]),
        .address(addrV[g]), .writeData(wdataV[g]), .readData(rdObs[g]),
        .ready(rdyObs[g]), .sramData(bus), .sramAddress(addrObs[g]),
        .sramCtrl(ctrlObs[g]), .dbgState(stObs[g])
      );
      // SRAM output enable is tied on: it drives the bus whenever WE_N is high.
      assign bus = ctrlObs[g][4] ? mem[g][addrObs[g][5:0]] : 16'hzzzz;
      assign busObs[g] = bus;
    end
  endgenerate

  // SRAM model: the write completes after acOf(k) consecutive WE_N-low cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!ctrlObs[k][4]) begin
        lastAddr[k] <= addrObs[k];
        if (weRun[k] != 0 && addrObs[k] == lastAddr[k]) begin
          weRun[k] <= weRun[k] + 1;
          if (weRun[k] + 1 == acOf(k)) mem[k][addrObs[k][5:0]] <= busObs[k];
        end else begin
          weRun[k] <= 1;
          if (acOf(k) == 1) mem[k][addrObs[k][5:0]] <= busObs[k];
        end
      end else begin
        weRun[k] <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request in the current IDLE cycle and follows it to DONE.
  task automatic access(input int k, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expRd, input string tag);
    int freeze;
    int weLow;
    bit done;
    freeze = 0;
    weLow  = 0;
    done   = 0;
    wrEnV[k] = w; rdEnV[k] = r; addrV[k] = a; wdataV[k] = d;
    @(negedge clk);
    check({tag, "_startIdle"}, 32'(stObs[k]), 32'd0);
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (!ctrlObs[k][4]) weLow++;
      if (rdyObs[k]) done = 1;
      else freeze++;
    end
    check({tag, "_reachedReady"}, 32'(done), 32'd1);
    check({tag, "_freeze"}, freeze, 2 * acOf(k) + 1);
    check({tag, "_weLowCycles"}, weLow, w ? 2 * acOf(k) : 0);
    check({tag, "_doneState"}, 32'(stObs[k]), 32'd3);
    check({tag, "_readData"}, rdObs[k], expRd);
    @(posedge clk);
    #1;
    wrEnV[k] = 1'b0;
    rdEnV[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wrEnV[k] = 1'b0; rdEnV[k] = 1'b0; addrV[k] = 32'd1024; wdataV[k] = 32'd0;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_ready", k), 32'(rdyObs[k]), 32'd1);
      check($sformatf("rst%0d_ctrl", k), 32'(ctrlObs[k]), 32'h10);
      check($sformatf("rst%0d_readData", k), rdObs[k], 32'd0);
      check($sformatf("rst%0d_sramAddress", k), 32'(addrObs[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ACCESS_CYCLES = 2
    access(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'd0, "wr1028");
    check("wr1028_hw2", 32'(mem[0][2]), 32'h0000BEEF);
    check("wr1028_hw3", 32'(mem[0][3]), 32'h0000DEAD);
    access(0, 1'b0, 1'b1, 32'd1028, 32'd0, 32'hDEADBEEF, "rd1028");
    access(0, 1'b1, 1'b0, 32'd1024, 32'h12345678, 32'hDEADBEEF, "b2bWr");
    access(0, 1'b0, 1'b1, 32'd1024, 32'd0, 32'h12345678, "b2bRd");
    check("b2b_hw0", 32'(mem[0][0]), 32'h00005678);
    check("b2b_hw1", 32'(mem[0][1]), 32'h00001234);
    access(0, 1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'h12345678, "bothEn");
    check("bothEn_hw4", 32'(mem[0][4]), 32'h00005A5A);
    check("bothEn_hw5", 32'(mem[0][5]), 32'h0000A5A5);
    access(0, 1'b1, 1'b0, 32'd1036, 32'h11112222, 32'h12345678, "pre1036");

    // Reset during the first cycle of HIGH of a store to 1036.
    wrEnV[0] = 1'b1; addrV[0] = 32'd1036; wdataV[0] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    check("midRst_inHigh", 32'(stObs[0]), 32'd2);
    check("midRst_weLowBefore", 32'(ctrlObs[0][4]), 32'd0);
    rst = 1'b1;
    wrEnV[0] = 1'b0;
    @(posedge clk);
    #1;
    check("midRst_idle", 32'(stObs[0]), 32'd0);
    check("midRst_ctrl", 32'(ctrlObs[0]), 32'h10);
    check("midRst_readData", rdObs[0], 32'd0);
    check("midRst_hw6", 32'(mem[0][6]), 32'h0000F00D);
    check("midRst_hw7", 32'(mem[0][7]), 32'h00001111);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ACCESS_CYCLES = 1 and 3, back-to-back store then load.
    access(1, 1'b1, 1'b0, 32'd1024, 32'h12345678, 32'd0, "ac1Wr");
    access(1, 1'b0, 1'b1, 32'd1024, 32'd0, 32'h12345678, "ac1Rd");
    check("ac1_hw0", 32'(mem[1][0]), 32'h00005678);
    check("ac1_hw1", 32'(mem[1][1]), 32'h00001234);
    access(2, 1'b1, 1'b0, 32'd1024, 32'h12345678, 32'd0, "ac3Wr");
    access(2, 1'b0, 1'b1, 32'd1024, 32'd0, 32'h12345678, "ac3Rd");
    access(2, 1'b1, 1'b0, 32'd1040, 32'hCAFEBABE, 32'h12345678, "ac3Wr2");
    access(2, 1'b0, 1'b1, 32'd1040, 32'd0, 32'hCAFEBABE, "ac3Rd2");
    check("ac3_hw8", 32'(mem[2][8]), 32'h0000BABE);
    check("ac3_hw9", 32'(mem[2][9]), 32'h0000CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
